// File: rtl/conv_pkg.sv
// Shared types and constants for the 1x1 convolution input feeder.
package conv_pkg;
  localparam int DATW  = 16;
  localparam int LANES = 16;

  // One packed lane word as exchanged with the feature-map/weight RAMs.
  typedef logic [LANES-1:0][DATW-1:0] lane_word_t;

  // Feeder sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Number of lane-word groups needed to cover all input channels.
  function automatic int groups_f(input int inch);
    return inch / LANES;
  endfunction
endpackage

// File: rtl/conv_addr_gen.sv
// Pixel/group counters and incrementing fm/wt address generators.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int GROUPS = 4,
  parameter int NPIX   = 4,
  parameter int OCW    = 6,
  parameter int PIXW   = 2,
  parameter int ADDRW  = 14,
  localparam int GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OCW-1:0]   oc_i,
  input  logic             issue_i,
  input  logic             next_pix_i,
  output logic [ADDRW-1:0] fm_addr_o,
  output logic [ADDRW-1:0] wt_addr_o,
  output logic [PIXW-1:0]  pix_o,
  output logic             g_first_o,
  output logic             g_last_o,
  output logic             pix_last_o
);
  logic [GW-1:0]    g_q, g_d;
  logic [PIXW-1:0]  pix_q, pix_d;
  logic [ADDRW-1:0] fm_q, fm_d, wt_q, wt_d, base_q, base_d;

  assign g_first_o  = (g_q == '0);
  assign g_last_o   = (g_q == GW'(GROUPS - 1));
  assign pix_last_o = (pix_q == PIXW'(NPIX - 1));
  assign fm_addr_o  = fm_q;
  assign wt_addr_o  = wt_q;
  assign pix_o      = pix_q;

  // Next-state: fm address runs straight through, wt address rewinds each pixel.
  always_comb begin
    g_d    = g_q;
    pix_d  = pix_q;
    fm_d   = fm_q;
    wt_d   = wt_q;
    base_d = base_q;
    if (load_i) begin
      g_d    = '0;
      pix_d  = '0;
      fm_d   = '0;
      base_d = ADDRW'(32'(oc_i) * GROUPS);
      wt_d   = ADDRW'(32'(oc_i) * GROUPS);
    end else begin
      if (issue_i) begin
        fm_d = fm_q + ADDRW'(1);
        if (g_last_o) begin
          g_d  = '0;
          wt_d = base_q;
        end else begin
          g_d  = g_q + GW'(1);
          wt_d = wt_q + ADDRW'(1);
        end
      end
      if (next_pix_i) pix_d = pix_q + PIXW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q    <= '0;
      pix_q  <= '0;
      fm_q   <= '0;
      wt_q   <= '0;
      base_q <= '0;
    end else begin
      g_q    <= g_d;
      pix_q  <= pix_d;
      fm_q   <= fm_d;
      wt_q   <= wt_d;
      base_q <= base_d;
    end
  end
endmodule

// File: rtl/conv1x1_feeder.sv
// Input-side sequencer for the 16-lane 1x1 convolution core.
// Optional build macro CONV1X1_FEEDER_PERF_EN adds the hold_cycles counter port.
module conv1x1_feeder
  import conv_pkg::*;
#(
  parameter int INCH   = 64,
  parameter int INSIZE = 55,
  parameter int OUTCH  = 64,
  parameter int ADDRW  = 14,
  localparam int GROUPS = groups_f(INCH),
  localparam int NPIX   = INSIZE * INSIZE,
  localparam int OCW    = (OUTCH > 1) ? $clog2(OUTCH) : 1,
  localparam int PIXW   = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OCW-1:0]   oc_idx,
  input  logic             hold,
  output logic [ADDRW-1:0] fm_addr,
  output logic             fm_rd,
  input  lane_word_t       fm_rdata,
  output logic [ADDRW-1:0] wt_addr,
  output logic             wt_rd,
  input  lane_word_t       wt_rdata,
  output lane_word_t       o_imgdata,
  output lane_word_t       o_kernel,
  output logic             o_data_valid,
  output logic             o_firstvalue,
  output logic             o_lastvalue,
  output logic [PIXW-1:0]  o_pix_idx,
  output logic             busy,
  output logic             done
`ifdef CONV1X1_FEEDER_PERF_EN
  , output logic [31:0]    hold_cycles
`endif
);
  if (INCH % LANES != 0) begin : g_bad_inch
    $error("INCH must be a multiple of LANES");
  end

  state_e          state_q;
  logic            busy_q, done_q;
  logic            vld_q, first_q, last_q;
  logic [PIXW-1:0] pix_idx_q;
  logic            load, issue, next_pix;
  logic            g_first, g_last, pix_last;
  logic [PIXW-1:0] pix;

  // The done cycle itself still refuses a new start.
  assign load     = (state_q == IDLE) && start && !done_q;
  assign issue    = (state_q == ISSUE);
  assign next_pix = (state_q == GAP) && !pix_last && !hold;

  conv_addr_gen #(
    .GROUPS(GROUPS), .NPIX(NPIX), .OCW(OCW), .PIXW(PIXW), .ADDRW(ADDRW)
  ) u_addr (
    .clk(clk), .rst(rst), .load_i(load), .oc_i(oc_idx), .issue_i(issue),
    .next_pix_i(next_pix), .fm_addr_o(fm_addr), .wt_addr_o(wt_addr),
    .pix_o(pix), .g_first_o(g_first), .g_last_o(g_last), .pix_last_o(pix_last)
  );

  // Sequencer: issue a pixel's groups back-to-back, then a gap that hold may stretch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:  if (load) begin
                 state_q <= ISSUE;
                 busy_q  <= 1'b1;
               end
        ISSUE: if (g_last) state_q <= GAP;
        GAP:   if (pix_last) state_q <= DRAIN;
               else if (!hold) state_q <= ISSUE;
        DRAIN: begin
                 state_q <= IDLE;
                 busy_q  <= 1'b0;
                 done_q  <= 1'b1;
               end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Beat qualifiers delayed one cycle to line up with RAM read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      pix_idx_q <= '0;
    end else begin
      vld_q   <= issue;
      first_q <= issue && g_first;
      last_q  <= issue && g_last;
      if (issue) pix_idx_q <= pix;
    end
  end

  assign fm_rd        = issue;
  assign wt_rd        = issue;
  assign o_imgdata    = fm_rdata;
  assign o_kernel     = wt_rdata;
  assign o_data_valid = vld_q;
  assign o_firstvalue = first_q;
  assign o_lastvalue  = last_q;
  assign o_pix_idx    = pix_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef CONV1X1_FEEDER_PERF_EN
  logic [31:0] hold_cnt_q;

  // Count gap cycles stretched by hold, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt_q <= '0;
    else if (load) hold_cnt_q <= '0;
    else if ((state_q == GAP) && !pix_last && hold && (hold_cnt_q != '1))
      hold_cnt_q <= hold_cnt_q + 32'd1;
  end

  assign hold_cycles = hold_cnt_q;
`endif
endmodule

// File: tb/tb_conv1x1_feeder.sv
// Self-checking bench: one 4-group and one 1-group feeder, 2x2 feature map.
module tb_conv1x1_feeder;
  logic         clk, rst;
  logic         start [2];
  logic [2:0]   oc_idx [2];
  logic         hold [2];
  logic [7:0]   fm_addr [2], wt_addr [2];
  logic         fm_rd [2], wt_rd [2];
  logic [255:0] fm_rdata [2], wt_rdata [2], o_imgdata [2], o_kernel [2];
  logic         o_data_valid [2], o_firstvalue [2], o_lastvalue [2];
  logic [1:0]   o_pix_idx [2];
  logic         busy [2], done [2];
`ifdef CONV1X1_FEEDER_PERF_EN
  logic [31:0]  hold_cycles [2];
`endif
  int n_chk = 0;
  int n_fail = 0;

  conv1x1_feeder #(.INCH(64), .INSIZE(2), .OUTCH(8), .ADDRW(8)) u_g4 (
    .clk(clk), .rst(rst), .start(start[0]), .oc_idx(oc_idx[0]), .hold(hold[0]),
    .fm_addr(fm_addr[0]), .fm_rd(fm_rd[0]), .fm_rdata(fm_rdata[0]),
    .wt_addr(wt_addr[0]), .wt_rd(wt_rd[0]), .wt_rdata(wt_rdata[0]),
    .o_imgdata(o_imgdata[0]), .o_kernel(o_kernel[0]), .o_data_valid(o_data_valid[0]),
    .o_firstvalue(o_firstvalue[0]), .o_lastvalue(o_lastvalue[0]),
    .o_pix_idx(o_pix_idx[0]), .busy(busy[0]), .done(done[0])
`ifdef CONV1X1_FEEDER_PERF_EN
    , .hold_cycles(hold_cycles[0])
`endif
  );

  conv1x1_feeder #(.INCH(16), .INSIZE(2), .OUTCH(8), .ADDRW(8)) u_g1 (
    .clk(clk), .rst(rst), .start(start[1]), .oc_idx(oc_idx[1]), .hold(hold[1]),
    .fm_addr(fm_addr[1]), .fm_rd(fm_rd[1]), .fm_rdata(fm_rdata[1]),
    .wt_addr(wt_addr[1]), .wt_rd(wt_rd[1]), .wt_rdata(wt_rdata[1]),
    .o_imgdata(o_imgdata[1]), .o_kernel(o_kernel[1]), .o_data_valid(o_data_valid[1]),
    .o_firstvalue(o_firstvalue[1]), .o_lastvalue(o_lastvalue[1]),
    .o_pix_idx(o_pix_idx[1]), .busy(busy[1]), .done(done[1])
`ifdef CONV1X1_FEEDER_PERF_EN
    , .hold_cycles(hold_cycles[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAMs returning address-tagged words.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fm_rd[i]) fm_rdata[i] <= {8{24'hF00000, fm_addr[i]}};
      if (wt_rd[i]) wt_rdata[i] <= {8{24'h0B0000, wt_addr[i]}};
    end
  end

  // Full run on instance d: expected beat timeline built from the rules, then checked per cycle.
  task automatic drive_and_check_run(input int d, input int oc, input int hold_pct, input bit noisy);
    int G, t, ext, done_c;
    bit hs [256];
    bit ev [258], ef [258], el [258];
    logic [7:0] efm [258], ewt [258];
    int ep [258];
    logic [255:0] eimg, eker;
    G = (d == 0) ? 4 : 1;
    for (int c = 0; c < 258; c++) begin
      if (c < 256) hs[c] = (c < 100) && ($urandom_range(99) < hold_pct);
      ev[c] = 0; ef[c] = 0; el[c] = 0; efm[c] = '0; ewt[c] = '0; ep[c] = 0;
    end
    t = 1; ext = 0;
    for (int p = 0; p < 4; p++) begin
      for (int g = 0; g < G; g++) begin
        ev[t+1] = 1; efm[t+1] = 8'(p*G + g); ewt[t+1] = 8'(oc*G + g);
        ef[t+1] = (g == 0); el[t+1] = (g == G-1); ep[t+1] = p;
        t++;
      end
      if (p == 3) t += 2;
      else begin
        while (hs[t]) begin t++; ext++; end
        t++;
      end
    end
    done_c = t;
    start[d] = 1'b1; oc_idx[d] = 3'(oc); hold[d] = hs[0];
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= done_c; c++) begin
      start[d] = 1'b0;
      n_chk++;
      if (o_data_valid[d] !== ev[c]) begin
        n_fail++; $display("FAIL valid d=%0d c=%0d got %b exp %b", d, c, o_data_valid[d], ev[c]);
      end
      if (ev[c]) begin
        eimg = {8{24'hF00000, efm[c]}};
        eker = {8{24'h0B0000, ewt[c]}};
        n_chk += 5;
        if (o_imgdata[d] !== eimg) begin
          n_fail++; $display("FAIL imgdata d=%0d c=%0d got %h exp %h", d, c, o_imgdata[d][31:0], eimg[31:0]);
        end
        if (o_kernel[d] !== eker) begin
          n_fail++; $display("FAIL kernel d=%0d c=%0d got %h exp %h", d, c, o_kernel[d][31:0], eker[31:0]);
        end
        if (o_firstvalue[d] !== ef[c]) begin
          n_fail++; $display("FAIL first d=%0d c=%0d got %b exp %b", d, c, o_firstvalue[d], ef[c]);
        end
        if (o_lastvalue[d] !== el[c]) begin
          n_fail++; $display("FAIL last d=%0d c=%0d got %b exp %b", d, c, o_lastvalue[d], el[c]);
        end
        if (o_pix_idx[d] !== 2'(ep[c])) begin
          n_fail++; $display("FAIL pix_idx d=%0d c=%0d got %0d exp %0d", d, c, o_pix_idx[d], ep[c]);
        end
      end
      n_chk += 2;
      if (fm_rd[d] !== ev[c+1] || wt_rd[d] !== ev[c+1]) begin
        n_fail++; $display("FAIL rd d=%0d c=%0d got %b/%b exp %b", d, c, fm_rd[d], wt_rd[d], ev[c+1]);
      end
      if ((ev[c+1] && (fm_addr[d] !== efm[c+1] || wt_addr[d] !== ewt[c+1]))) begin
        n_fail++; $display("FAIL addr d=%0d c=%0d got %0d/%0d exp %0d/%0d", d, c,
                           fm_addr[d], wt_addr[d], efm[c+1], ewt[c+1]);
      end
      n_chk += 2;
      if (busy[d] !== (c < done_c)) begin
        n_fail++; $display("FAIL busy d=%0d c=%0d got %b exp %b", d, c, busy[d], (c < done_c));
      end
      if (done[d] !== (c == done_c)) begin
        n_fail++; $display("FAIL done d=%0d c=%0d got %b exp %b", d, c, done[d], (c == done_c));
      end
      hold[d] = (c < 256) ? hs[c] : 1'b0;
      if (c == done_c || (noisy && $urandom_range(3) == 0)) begin
        start[d] = 1'b1; oc_idx[d] = 3'($urandom);
      end
      @(posedge clk); @(negedge clk);
    end
    start[d] = 1'b0; hold[d] = 1'b0;
    n_chk++;
    if (busy[d] !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_done d=%0d got busy %b exp 0", d, busy[d]);
    end
`ifdef CONV1X1_FEEDER_PERF_EN
    n_chk++;
    if (hold_cycles[d] !== 32'(ext)) begin
      n_fail++; $display("FAIL hold_cycles d=%0d got %0d exp %0d", d, hold_cycles[d], ext);
    end
`endif
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      n_chk += 4;
      if (fm_rd[d] !== 1'b0 || wt_rd[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_rd d=%0d got %b/%b exp 0", d, fm_rd[d], wt_rd[d]);
      end
      if (fm_addr[d] !== 8'd0 || wt_addr[d] !== 8'd0) begin
        n_fail++; $display("FAIL reset_addr d=%0d got %0d/%0d exp 0", d, fm_addr[d], wt_addr[d]);
      end
      if (o_data_valid[d] !== 1'b0 || o_firstvalue[d] !== 1'b0 || o_lastvalue[d] !== 1'b0 ||
          o_pix_idx[d] !== 2'd0) begin
        n_fail++; $display("FAIL reset_beat d=%0d got %b%b%b pix %0d exp 0", d,
                           o_data_valid[d], o_firstvalue[d], o_lastvalue[d], o_pix_idx[d]);
      end
      if (busy[d] !== 1'b0 || done[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy d=%0d got %b/%b exp 0", d, busy[d], done[d]);
      end
`ifdef CONV1X1_FEEDER_PERF_EN
      n_chk++;
      if (hold_cycles[d] !== 32'd0) begin
        n_fail++; $display("FAIL reset_hold_cycles d=%0d got %0d exp 0", d, hold_cycles[d]);
      end
`endif
    end
  endtask

  task automatic test_basic;
    drive_and_check_run(0, 3, 0, 0);
    drive_and_check_run(0, 0, 0, 0);
    drive_and_check_run(0, 7, 0, 0);
  endtask

  task automatic test_hold;
    repeat (4) drive_and_check_run(0, $urandom_range(7), 40, 0);
  endtask

  task automatic test_back_to_back;
    repeat (3) drive_and_check_run(0, $urandom_range(7), 20, 1);
  endtask

  task automatic test_groups1;
    repeat (3) drive_and_check_run(1, $urandom_range(7), 30, 1);
  endtask

  task automatic test_reset_mid;
    start[0] = 1'b1; oc_idx[0] = 3'd5; hold[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    start[0] = 1'b0;
    repeat (11) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    n_chk++;
    if (busy[0] !== 1'b1 && o_pix_idx[0] !== 2'd0) begin
      // reached only if the run was not underway when reset hit
    end
    test_reset;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      n_chk++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle c=%0d got busy %b done %b exp 0", c, busy[0], done[0]);
      end
      @(posedge clk); @(negedge clk);
    end
    drive_and_check_run(0, 2, 20, 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; oc_idx[d] = '0; hold[d] = 1'b0;
    end
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_basic;
    test_hold;
    test_back_to_back;
    test_groups1;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
